// File: rtl/seq_adder_pn.sv
// seq_adder_pn: multi-cycle adder, CHUNK bits per clock (LSB chunk first), start/busy/done handshake.
// Optional: define SEQ_ADDER_SUB_EN to add a `sub` input selecting a - b (a + ~b + 1).
module seq_adder_pn #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
`ifdef SEQ_ADDER_SUB_EN
   input  logic             sub,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   localparam int unsigned N  = WIDTH / CHUNK;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   if (WIDTH < 2 || CHUNK == 0 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
      $error("seq_adder_pn: need WIDTH >= 2, 1 <= CHUNK <= WIDTH, WIDTH %% CHUNK == 0");
   end

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic             c_q, c_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] part_q, part_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic [CHUNK:0]   chunk_sum;
   logic [WIDTH-1:0] b_in;
   logic             c_in;

`ifdef SEQ_ADDER_SUB_EN
   // Subtract: invert b at latch time and force the initial carry to 1, ignoring cin.
   assign b_in = sub ? ~b : b;
   assign c_in = sub | cin;
`else
   assign b_in = b;
   assign c_in = cin;
`endif

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      c_d       = c_q;
      cnt_d     = cnt_q;
      part_d    = part_q;
      sum_d     = sum_q;
      carry_d   = carry_q;
      chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_q};
      unique case (state_q)
         StIdle, StDone: begin
            state_d = StIdle;
            if (start) begin
               state_d = StRun;
               a_d     = a;
               b_d     = b_in;
               c_d     = c_in;
               cnt_d   = '0;
               part_d  = '0;
            end
         end
         StRun: begin
            // Operands shift down so the active chunk is always in the low bits; result
            // chunks enter at the top and reach their final position after N shifts.
            a_d    = a_q >> CHUNK;
            b_d    = b_q >> CHUNK;
            c_d    = chunk_sum[CHUNK];
            part_d = WIDTH'({chunk_sum[CHUNK-1:0], part_q} >> CHUNK);
            if (cnt_q == CW'(N - 1)) begin
               cnt_d   = '0;
               sum_d   = part_d;
               carry_d = chunk_sum[CHUNK];
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         part_q  <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         part_q  <= part_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
      end
   end

   assign busy  = (state_q == StRun);
   assign done  = (state_q == StDone);
   assign sum   = sum_q;
   assign carry = carry_q;

endmodule
